vga_scan_gen: RTL and testbench

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

---
 rtl/vga_pkg.sv | 15 +
 rtl/pix_div.sv | 15 +
 rtl/vga_scan_gen.sv | 70 +++++++
 tb/tb_vga_scan_gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants (640x480 defaults) and counter decode helpers
// used by the scan generator and by glyph modules that consume x/y.
package vga_pkg;
  localparam int CNT_W = 10;
  localparam int RGB_W = 12;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END = 751;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END = 491;
  function automatic logic in_span(logic [CNT_W-1:0] c, int lo, int hi);
    return int'(c) >= lo && int'(c) <= hi;
  endfunction
endpackage

// File: rtl/pix_div.sv
// pix_div: free-running clk divider; tick is high for the last clk of each pixel period.
module pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster counters, sync generation and colour output for an external glyph decoder.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter logic [RGB_W-1:0] FG_RGB = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_RGB = 12'h000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  input  logic             display,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start
);
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;
  logic [CNT_W-1:0] hcount, vcount, h_next, v_next;
  logic             h_wrap, video_on;
  logic [RGB_W-1:0] pix;
  pix_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (p_tick)
  );
  // >= / > comparisons also pull any corrupted counter value back to 0
  always_comb begin
    h_wrap = hcount >= H_LAST;
    h_next = h_wrap ? '0 : hcount + 1'b1;
    v_next = vcount > V_LAST ? '0 : !h_wrap ? vcount : vcount == V_LAST ? '0 : vcount + 1'b1;
    video_on = hcount < H_ACT && vcount < V_ACT;
    pix = video_on ? (display ? FG_RGB : BG_RGB) : '0;
  end
  // colour and syncs are registered from the presented (x,y), so all three lag x/y by one pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
      rgb    <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else if (p_tick) begin
      hcount <= h_next;
      vcount <= v_next;
      rgb    <= pix;
      hsync  <= !in_span(hcount, HS_LO, HS_HI);
      vsync  <= !in_span(vcount, VS_LO, VS_HI);
    end
  assign x = hcount;
  assign y = vcount;
  assign frame_start = p_tick && hcount == '0 && vcount == '0;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: scoreboard bench on a reduced 16x8 raster (10x4 active, CLK_DIV=4) so whole frames fit in a short run.
module tb_vga_scan_gen;
  logic        clk = 1'b0;
  logic        rst_n, display, p_tick, hsync, vsync, frame_start;
  logic [9:0]  x, y;
  logic [11:0] rgb;
  int n_chk = 0, n_fail = 0, n_tick = 0, n_fff = 0, n_hlow = 0, n_vlow = 0;
  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        fs;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;
  exp_t q[$];
  exp_t pexp, cur;
  bit   pend;
  time  fs_t[$];

  always #5 clk = ~clk;

  vga_scan_gen #(
    .CLK_DIV(4), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FG_RGB(12'hFFF), .BG_RGB(12'h0A5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .display(display), .p_tick(p_tick),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // tick k after reset presents h=k%16, v=(k/16)%8; sync windows h 12..14, v 5..6
  function automatic exp_t model(int k, logic d);
    exp_t e;
    int h = k % 16;
    int v = (k / 16) % 8;
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.fs  = h == 0 && v == 0;
    e.rgb = (h < 10 && v < 4) ? (d ? 12'hFFF : 12'h0A5) : 12'h000;
    e.hs  = !(h >= 12 && h <= 14);
    e.vs  = !(v >= 5 && v <= 6);
    return e;
  endfunction

  // one clk: i counts posedges since reset release; tick k is presented after posedge 4k+3
  task automatic cyc(input int i, input bit ones);
    int k = i / 4;
    logic d;
    @(posedge clk);
    @(negedge clk);
    d = ones ? 1'b1 : logic'(k[0] ^ k[2]);
    if (i % 4 == 3) begin
      display = d;
      q.push_back(model(k, d));
    end else display = ~d;
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      cur  = '{h: 10'd0, v: 10'd0, fs: 1'b0, rgb: 12'h000, hs: 1'b1, vs: 1'b1};
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("rgb", rgb, pexp.rgb);
        chk("hsync", hsync, pexp.hs);
        chk("vsync", vsync, pexp.vs);
        n_fff  += int'(rgb == 12'hFFF);
        n_hlow += int'(!hsync);
        n_vlow += int'(!vsync);
        cur  = pexp;
        pend = 1'b0;
      end else chk("hold", {rgb, hsync, vsync}, {cur.rgb, cur.hs, cur.vs});
      if (p_tick) begin
        n_tick++;
        if (frame_start) fs_t.push_back($time);
        chk("tick_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          pexp = q.pop_front();
          pend = 1'b1;
          chk("x", x, pexp.h);
          chk("y", y, pexp.v);
          chk("frame_start", frame_start, pexp.fs);
        end
      end else chk("frame_start_idle", frame_start, 0);
    end
  end

  initial begin
    rst_n   = 1'b0;
    display = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_sync", {hsync, vsync}, 2'b11);
    chk("rst_strobes", {p_tick, frame_start}, 2'b00);
    chk("rst_xy", {x, y}, 20'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 1181; i++) begin
      cyc(i, (i / 4) < 128);
      if (i == 64) begin
        chk("line_ticks", n_tick, 16);
        chk("line_x", x, 0);
        chk("line_y", y, 1);
      end
      if (i == 514) begin
        chk("frame_fg_ticks", n_fff, 40);
        chk("frame_hsync_low", n_hlow, 24);
        chk("frame_vsync_low", n_vlow, 32);
      end
      if (i == 1024) begin
        chk("two_frame_starts", fs_t.size(), 2);
        if (fs_t.size() >= 2) chk("frame_period", 32'(fs_t[1] - fs_t[0]), 5120);
      end
    end
    chk("pre_rst_x", x, 7);
    chk("pre_rst_y", y, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb", rgb, 12'h000);
    chk("arst_sync", {hsync, vsync}, 2'b11);
    chk("arst_strobes", {p_tick, frame_start}, 2'b00);
    chk("arst_xy", {x, y}, 20'h0);
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 84; i++) begin
      cyc(i, 1'b0);
      if (i == 2) chk("restart_no_tick", p_tick, 0);
      if (i == 3) chk("restart_tick", p_tick, 1);
    end
    @(negedge clk);
    #2;
    chk("total_ticks", n_tick, 316);
    chk("total_frame_starts", fs_t.size(), 4);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
